// File: rtl/ecc_result_collector_if.sv
// Result bus between the ECC checker pipe, the collector and the downstream consumer.
// The arrival side carries checker results in; the head side presents the oldest entry.
interface ecc_result_collector_if #(
  parameter int data_width = 27,
  parameter int chk_width  = 7,
  parameter int id_width   = 1
);
  logic                  arrive;
  logic [id_width-1:0]   arrive_id;
  logic [data_width-1:0] in_data;
  logic                  in_err_detect;
  logic                  in_err_multi;
  logic [chk_width-1:0]  in_synd;
  logic                  accept_n;
  logic                  out_valid;
  logic [data_width-1:0] out_data;
  logic [id_width-1:0]   out_id;
  logic [1:0]            out_class;
  logic                  pop;

  // Collector side
  modport slave (
    input  arrive, arrive_id, in_data, in_err_detect, in_err_multi, in_synd, pop,
    output accept_n, out_valid, out_data, out_id, out_class
  );

  // Pipe / consumer side
  modport master (
    output arrive, arrive_id, in_data, in_err_detect, in_err_multi, in_synd, pop,
    input  accept_n, out_valid, out_data, out_id, out_class
  );
endinterface

// File: rtl/ecc_result_collector.sv
// Captures ECC checker results into a small FIFO, classifies them and keeps
// saturating error statistics plus sticky flags for the scrub/CSR logic.
module ecc_result_collector #(
  parameter int data_width = 27,
  parameter int chk_width  = 7,
  parameter int id_width   = 1,
  parameter int depth      = 4,
  parameter int cnt_width  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ecc_result_collector_if.slave        bus,
  input  logic                         clr,
  output logic [$clog2(depth+1)-1:0]   fifo_count,
  output logic [cnt_width-1:0]         corr_cnt,
  output logic [cnt_width-1:0]         uncorr_cnt,
  output logic [chk_width-1:0]         last_synd,
  output logic [id_width-1:0]          last_id,
  output logic                         uncorr_flag,
  output logic                         ovf_flag
);
  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam int EW = 2 + id_width + data_width;

  logic [EW-1:0]         mem [depth];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic                  accept_n_reg;
  logic [cnt_width-1:0]  corr_cnt_reg, uncorr_cnt_reg;
  logic [chk_width-1:0]  last_synd_reg;
  logic [id_width-1:0]   last_id_reg;
  logic                  uncorr_flag_reg, ovf_flag_reg;

  logic [1:0]            in_class;
  logic                  pop_eff, push, drop;
  logic                  is_corr, is_uncorr, is_err;
  logic [EW-1:0]         head;

  always_comb begin
    in_class  = bus.in_err_multi ? 2'b11 : (bus.in_err_detect ? 2'b01 : 2'b00);
    is_corr   = bus.arrive && (in_class == 2'b01);
    is_uncorr = bus.arrive && (in_class == 2'b11);
    is_err    = is_corr || is_uncorr;
    pop_eff   = bus.pop && (count_reg != '0);
    // A full FIFO still takes an arrival when the head leaves in the same cycle.
    push      = bus.arrive && ((count_reg < CW'(depth)) || pop_eff);
    drop      = bus.arrive && !push;
    count_next = count_reg + CW'(push) - CW'(pop_eff);
  end

  // Storage is not reset; head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {in_class, bus.arrive_id, bus.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      accept_n_reg <= 1'b0;
    end else begin
      if (push)    wr_ptr_reg <= (wr_ptr_reg == PW'(depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop_eff) rd_ptr_reg <= (rd_ptr_reg == PW'(depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      // Stall one slot early so the arrival already in flight still fits.
      accept_n_reg <= (count_next >= CW'(depth - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_reg    <= '0;
      uncorr_cnt_reg  <= '0;
      last_synd_reg   <= '0;
      last_id_reg     <= '0;
      uncorr_flag_reg <= 1'b0;
      ovf_flag_reg    <= 1'b0;
    end else if (clr) begin
      // The clearing cycle's own arrival is still recorded.
      corr_cnt_reg    <= cnt_width'(is_corr);
      uncorr_cnt_reg  <= cnt_width'(is_uncorr);
      uncorr_flag_reg <= is_uncorr;
      ovf_flag_reg    <= drop;
      last_synd_reg   <= is_err ? bus.in_synd   : '0;
      last_id_reg     <= is_err ? bus.arrive_id : '0;
    end else begin
      if (is_corr && (corr_cnt_reg != '1))     corr_cnt_reg   <= corr_cnt_reg + 1'b1;
      if (is_uncorr && (uncorr_cnt_reg != '1)) uncorr_cnt_reg <= uncorr_cnt_reg + 1'b1;
      if (is_uncorr) uncorr_flag_reg <= 1'b1;
      if (drop)      ovf_flag_reg    <= 1'b1;
      if (is_err) begin
        last_synd_reg <= bus.in_synd;
        last_id_reg   <= bus.arrive_id;
      end
    end
  end

  always_comb begin
    head          = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    bus.out_valid = (count_reg != '0);
    bus.out_data  = head[data_width-1:0];
    bus.out_id    = head[data_width +: id_width];
    bus.out_class = head[EW-1 -: 2];
    bus.accept_n  = accept_n_reg;
    fifo_count    = count_reg;
    corr_cnt      = corr_cnt_reg;
    uncorr_cnt    = uncorr_cnt_reg;
    last_synd     = last_synd_reg;
    last_id       = last_id_reg;
    uncorr_flag   = uncorr_flag_reg;
    ovf_flag      = ovf_flag_reg;
  end
endmodule

// File: tb/tb_ecc_result_collector.sv
// Randomized and directed bench for ecc_result_collector against a queue-based
// reference model of the collector's behaviour.
module tb_ecc_result_collector;
  localparam int DW = 27, KW = 7, IW = 1, DEPTH = 4, NW = 8;
  localparam int CMAX = (1 << NW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [NW-1:0] corr_cnt, uncorr_cnt;
  logic [KW-1:0] last_synd;
  logic [IW-1:0] last_id;
  logic uncorr_flag, ovf_flag;

  ecc_result_collector_if #(.data_width(DW), .chk_width(KW), .id_width(IW)) bus ();

  ecc_result_collector #(.data_width(DW), .chk_width(KW), .id_width(IW),
                         .depth(DEPTH), .cnt_width(NW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .clr(clr),
    .fifo_count(fifo_count), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .last_synd(last_synd), .last_id(last_id),
    .uncorr_flag(uncorr_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    cls;
  } entry_t;

  entry_t q[$];
  int m_corr, m_uncorr;
  logic [KW-1:0] m_synd;
  logic [IW-1:0] m_id;
  logic m_uflag, m_oflag;
  int passed = 0, total = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    q.delete();
    m_corr = 0; m_uncorr = 0; m_synd = '0; m_id = '0; m_uflag = 0; m_oflag = 0;
  endtask

  task automatic check_all();
    entry_t h;
    h.data = '0; h.id = '0; h.cls = 2'b00;
    if (q.size() > 0) h = q[0];
    check("count",     64'(fifo_count), 64'(q.size()));
    check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    check("accept_n",  64'(bus.accept_n), 64'(q.size() >= DEPTH - 1));
    check("out_data",  64'(bus.out_data), 64'(h.data));
    check("out_id",    64'(bus.out_id), 64'(h.id));
    check("out_class", 64'(bus.out_class), 64'(h.cls));
    check("corr_cnt",  64'(corr_cnt), 64'(m_corr));
    check("uncorr_cnt",64'(uncorr_cnt), 64'(m_uncorr));
    check("last_synd", 64'(last_synd), 64'(m_synd));
    check("last_id",   64'(last_id), 64'(m_id));
    check("uncorr_flag", 64'(uncorr_flag), 64'(m_uflag));
    check("ovf_flag",  64'(ovf_flag), 64'(m_oflag));
  endtask

  // One clock of stimulus: drive, clock, advance the model, compare everything.
  task automatic step(input logic a, input logic [IW-1:0] id, input logic [DW-1:0] d,
                      input logic det, input logic multi, input logic [KW-1:0] s,
                      input logic p, input logic c);
    logic [1:0] cls;
    bit pop_e, push_e, drop_e, err;
    bus.arrive = a; bus.arrive_id = id; bus.in_data = d;
    bus.in_err_detect = det; bus.in_err_multi = multi; bus.in_synd = s;
    bus.pop = p; clr = c;
    @(posedge clk);
    cyc++;
    cls    = multi ? 2'b11 : (det ? 2'b01 : 2'b00);
    pop_e  = p && (q.size() > 0);
    push_e = a && ((q.size() < DEPTH) || pop_e);
    drop_e = a && !push_e;
    err    = a && (cls != 2'b00);
    if (pop_e) void'(q.pop_front());
    if (push_e) q.push_back('{data: d, id: id, cls: cls});
    if (c) begin
      m_corr   = (a && cls == 2'b01) ? 1 : 0;
      m_uncorr = (a && cls == 2'b11) ? 1 : 0;
      m_uflag  = (a && cls == 2'b11);
      m_oflag  = drop_e;
      m_synd   = err ? s : '0;
      m_id     = err ? id : '0;
    end else begin
      if (a && cls == 2'b01 && m_corr < CMAX)   m_corr++;
      if (a && cls == 2'b11 && m_uncorr < CMAX) m_uncorr++;
      if (a && cls == 2'b11) m_uflag = 1;
      if (drop_e) m_oflag = 1;
      if (err) begin m_synd = s; m_id = id; end
    end
    #1;
    $display("cyc %0d arrive=%0b cls=%0b pop=%0b clr=%0b count=%0d corr=%0d uncorr=%0d",
             cyc, a, cls, p, c, fifo_count, corr_cnt, uncorr_cnt);
    check_all();
  endtask

  task automatic idle_pop(input logic p);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, p, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) idle_pop(1'b1);
  endtask

  initial begin
    bus.arrive = 0; bus.arrive_id = '0; bus.in_data = '0; bus.in_err_detect = 0;
    bus.in_err_multi = 0; bus.in_synd = '0; bus.pop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Three clean arrivals with no pop
    for (int i = 0; i < 3; i++) step(1'b1, IW'(i), DW'(32'h100 + i), 0, 0, '0, 0, 0);
    check("t1_count", 64'(fifo_count), 64'd3);
    check("t1_accept_n", 64'(bus.accept_n), 64'd1);
    check("t1_class", 64'(bus.out_class), 64'd0);
    drain();

    // Single corrected result
    step(1'b1, 1'b1, DW'(32'h5a5a5a), 1, 0, 7'h15, 0, 0);
    check("t2_corr", 64'(corr_cnt), 64'd1);
    check("t2_synd", 64'(last_synd), 64'h15);
    check("t2_id", 64'(last_id), 64'd1);
    check("t2_class", 64'(bus.out_class), 64'b01);
    drain();

    // Uncorrectable result, multi takes priority over detect
    step(1'b1, 1'b0, DW'(32'h3), 1, 1, 7'h22, 0, 0);
    check("t3_class", 64'(bus.out_class), 64'b11);
    check("t3_uncorr", 64'(uncorr_cnt), 64'd1);
    check("t3_uflag", 64'(uncorr_flag), 64'd1);
    check("t3_corr", 64'(corr_cnt), 64'd1);
    drain();

    // Overflow: fill, arrive without pop, then with pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, '0, DW'(i), 0, 0, '0, 0, 0);
    step(1'b1, '0, DW'(32'hdead), 0, 0, '0, 0, 0);
    check("t4_ovf", 64'(ovf_flag), 64'd1);
    check("t4_count", 64'(fifo_count), 64'd4);
    step(1'b0, '0, '0, 0, 0, '0, 0, 1);
    step(1'b1, '0, DW'(32'hbeef), 0, 0, '0, 1, 0);
    check("t4_count_pop", 64'(fifo_count), 64'd4);
    check("t4_no_ovf", 64'(ovf_flag), 64'd0);
    drain();

    // Saturation then clear with simultaneous corrected arrival
    for (int i = 0; i < 260; i++) step(1'b1, '0, DW'(i), 1, 0, 7'h01, 1, 0);
    check("t5_sat", 64'(corr_cnt), 64'd255);
    step(1'b1, '0, DW'(7), 1, 0, 7'h09, 1, 1);
    check("t5_clr", 64'(corr_cnt), 64'd1);
    drain();

    // Asynchronous reset mid-stream
    step(1'b1, '0, DW'(1), 0, 0, '0, 0, 0);
    step(1'b1, '0, DW'(2), 0, 0, '0, 0, 0);
    bus.arrive = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_count", 64'(fifo_count), 64'd0);
    check("t6_accept_n", 64'(bus.accept_n), 64'd0);
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, IW'($urandom), DW'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, KW'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
